// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Owns the PC, addresses a combinational instruction memory and registers the
// returned word into IF/ID. Handles stall, redirect-with-flush and halt on an
// all-zero word. A two-state FSM (RUN/HALT) is visible on the halted output.
//
// Handshake: id_stall is a level "not ready" from decode. While it is high in
// RUN the PC and IF/ID hold. redirect_valid is a single-cycle command that is
// accepted on the edge where it is sampled high, regardless of id_stall or
// state.
//
// Optional feature macro: FETCH_FAULT_CHECK_EN. When defined, a fetch from a
// misaligned or out-of-range PC loads a faulting bubble into IF/ID and halts.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic        fault_id,
  output logic        halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcid_q, pcid_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        zero_word;
  logic        fetch_fault;

  assign imem_addr = pc_q;
  assign zero_word = (imem_inst == 32'h0);

`ifdef FETCH_FAULT_CHECK_EN
  // Word index beyond the memory or a non-word-aligned PC cannot be fetched.
  assign fetch_fault = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= DEPTH_W);
`else
  assign fetch_fault = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: redirect > stall > fault/zero-word halt > advance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (!redirect_valid && !id_stall && (fetch_fault || zero_word))
          state_d = ST_HALT;
      end
      ST_HALT: begin
        if (redirect_valid) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: halted reflects the registered state.
  always_comb begin
    halted = (state_q == ST_HALT);
  end

  // Next PC and next IF/ID contents under the same priority as the FSM.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcid_d  = pcid_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      // Flush: bubble into IF/ID, pc_id keeps its last value.
      pc_d    = redirect_pc;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (state_q == ST_HALT) begin
      // Halted fetch emits bubbles every cycle; stall has no effect here.
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (id_stall) begin
      // Hold everything.
    end else if (fetch_fault) begin
      // The faulting fetch is passed to decode as a valid, flagged bubble.
      inst_d  = NOP_INST;
      pcid_d  = pc_q;
      valid_d = 1'b1;
      fault_d = 1'b1;
    end else if (zero_word) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else begin
      inst_d  = imem_inst;
      pcid_d  = pc_q;
      valid_d = 1'b1;
      fault_d = 1'b0;
      pc_d    = pc_q + 32'd4;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pcid_q  <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcid_q  <= pcid_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign inst_id  = inst_q;
  assign pc_id    = pcid_q;
  assign valid_id = valid_q;
  assign fault_id = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a behavioural model
// of PC / IF/ID / halt behaviour and randomized stall/redirect stimulus.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int W = 99;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        valid_id;
  logic        fault_id;
  logic        halted;

  logic [31:0] imem [256];

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  // model state
  logic [31:0] m_pc, m_inst, m_pcid;
  logic        m_valid, m_fault, m_halt;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_id        (inst_id),
    .pc_id          (pc_id),
    .valid_id       (valid_id),
    .fault_id       (fault_id),
    .halted         (halted)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time exceeded, queue=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  // Memory: rows in range return the table; anything beyond returns a
  // non-zero word derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd1024) return imem[a[9:2]];
    return a | 32'h1;
  endfunction

  always_comb imem_inst = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = NOP; m_pcid = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_id", inst_id, NOP);
    check("rst_pc_id", pc_id, 32'h0);
    check("rst_valid_id", {31'h0, valid_id}, 32'h0);
    check("rst_fault_id", {31'h0, fault_id}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
  endtask

  // driver: one clock of stimulus; model computes what IF/ID and PC must be
  // after the edge, and the expectation is queued for the monitor.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc);
    logic [31:0] w;
    logic        flt;
    id_stall       = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    w   = mem_word(m_pc);
    flt = 1'b0;
`ifdef FETCH_FAULT_CHECK_EN
    flt = (m_pc % 4 != 0) || (m_pc >= 32'd1024);
`endif
    if (rv) begin
      m_pc = rpc; m_inst = NOP; m_valid = 0; m_fault = 0; m_halt = 0;
    end else if (m_halt) begin
      m_inst = NOP; m_valid = 0; m_fault = 0;
    end else if (st) begin
      // nothing moves
    end else if (flt) begin
      m_inst = NOP; m_pcid = m_pc; m_valid = 1; m_fault = 1; m_halt = 1;
    end else if (w == 32'h0) begin
      m_inst = NOP; m_valid = 0; m_fault = 0; m_halt = 1;
    end else begin
      m_inst = w; m_pcid = m_pc; m_valid = 1; m_fault = 0; m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    exp_q.push_back({m_pc, m_inst, m_pcid, m_valid, m_fault, m_halt});
    #1;
  endtask

  // driver: reset asserted between edges, checked with no clock edge
  task automatic reset_mid();
    @(negedge clk);
    #1;
    id_stall = 0; redirect_valid = 0; redirect_pc = 0;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("imem_addr", imem_addr, e[98:67]);
      check("inst_id", inst_id, e[66:35]);
      check("pc_id", pc_id, e[34:3]);
      check("valid_id", {31'h0, valid_id}, {31'h0, e[2]});
      check("fault_id", {31'h0, fault_id}, {31'h0, e[1]});
      check("halted", {31'h0, halted}, {31'h0, e[0]});
    end
  end

  initial begin
    logic [31:0] rpc;
    int sel;
    // memory contents: non-zero words, directed rows, scattered zero rows
    for (int i = 0; i < 256; i++) imem[i] = $urandom() | 32'h1;
    imem[0] = 32'h0031_00B3; // add x1,x2,x3
    imem[1] = 32'h4031_00B3; // sub x1,x2,x3
    imem[2] = 32'h0031_40B3; // xor x1,x2,x3
    imem[5] = 32'h0;
    for (int i = 0; i < 8; i++) imem[$urandom_range(20, 255)] = 32'h0;

    id_stall = 0; redirect_valid = 0; redirect_pc = 0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // sequential fetch of rows 0..2
    repeat (3) cycle(0, 0, 0);
    // stall holds PC and IF/ID, then release
    repeat (2) cycle(1, 0, 0);
    cycle(0, 0, 0);
    // redirect overrides stall
    cycle(1, 1, 32'h40);
    repeat (2) cycle(0, 0, 0);
    // zero word at row 5 halts; stall ignored while halted; redirect resumes
    cycle(0, 1, 32'h0C);
    repeat (3) cycle(0, 0, 0);
    repeat (2) cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 32'h0);
    repeat (2) cycle(0, 0, 0);
    // asynchronous reset mid-stream at pc 0x10
    repeat (2) cycle(0, 0, 0);
    reset_mid();
    repeat (2) cycle(0, 0, 0);
    // PC wrap from the top of the address space
    cycle(0, 1, 32'hFFFF_FFFC);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 1, 32'h3FC);
    repeat (3) cycle(0, 0, 0);
`ifdef FETCH_FAULT_CHECK_EN
    cycle(0, 1, 32'h402);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 1, 32'h400);
    cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);
    cycle(0, 1, 32'h0);
    cycle(0, 0, 0);
`endif

    // randomized stall / redirect traffic
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 14)      rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      else if (sel < 17) rpc = (sel == 14) ? 32'h3F8 : (sel == 15) ? 32'hFFFF_FFF8 : 32'h400;
      else               rpc = {22'h0, 10'($urandom_range(0, 1023))};
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rpc);
      if ($urandom_range(0, 199) == 0) reset_mid();
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
